// File: rtl/score_seg_display.sv
// Score display for the Simon game: serial double-dabble BCD conversion feeding a
// time-multiplexed 4-digit common-anode 7-segment display with PowerOn/GameOver overrides.
module score_seg_display #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLINK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] score,
    input  logic [2:0] state,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       bcd_valid
);

    localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [2:0] STATE_POWER_ON  = 3'd0;
    localparam logic [2:0] STATE_GAME_OVER = 3'd7;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic [1:0] {StIdle, StShift, StDone} conv_state_e;

    conv_state_e conv_q, conv_d;

    logic              pending_q;
    logic [9:0]        last_score_q;
    logic [9:0]        shift_q;
    logic [13:0]       bcd_q;
    logic [13:0]       bcd_adj;
    logic [3:0]        iter_q;
    logic [3:0][3:0]   digits_q;

    logic              start;
    logic              load;
    logic              shift_en;
    logic              done;

    logic [SCAN_W-1:0]  scan_cnt_q;
    logic [1:0]         idx_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_phase_q;

    logic [3:0]        blank;
    logic [6:0]        seg_d;
    logic [3:0]        an_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = SEG_OFF;
        endcase
    endfunction

    // Converter FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_q <= StIdle;
        end else begin
            conv_q <= conv_d;
        end
    end

    assign start = pending_q || (score != last_score_q);

    // Converter FSM: next state
    always_comb begin
        conv_d = conv_q;
        unique case (conv_q)
            StIdle:  if (start) conv_d = StShift;
            StShift: if (iter_q == 4'd9) conv_d = StDone;
            StDone:  conv_d = StIdle;
            default: conv_d = StIdle;
        endcase
    end

    // Converter FSM: control outputs
    always_comb begin
        load     = 1'b0;
        shift_en = 1'b0;
        done     = 1'b0;
        unique case (conv_q)
            StIdle:  load = start;
            StShift: shift_en = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // The top 2-bit nibble never exceeds 1 for a 10-bit input, so it needs no correction.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < 3; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= 1'b1;
            last_score_q <= '0;
            shift_q      <= '0;
            bcd_q        <= '0;
            iter_q       <= '0;
            digits_q     <= '0;
            bcd_valid    <= 1'b0;
        end else begin
            if (load) begin
                shift_q      <= score;
                last_score_q <= score;
                bcd_q        <= '0;
                iter_q       <= '0;
                pending_q    <= 1'b0;
                bcd_valid    <= 1'b0;
            end
            if (shift_en) begin
                {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
                iter_q           <= iter_q + 4'd1;
            end
            if (done) begin
                digits_q  <= {2'b00, bcd_q[13:12], bcd_q[11:8], bcd_q[7:4], bcd_q[3:0]};
                bcd_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
        end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            idx_q      <= idx_q + 2'd1;
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
        end
    end

    // Blink timing restarts on every GameOver entry so the display always starts lit.
    always_ff @(posedge clk) begin
        if (rst || state != STATE_GAME_OVER) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    always_comb begin
        blank[3] = (digits_q[3] == 4'd0);
        blank[2] = blank[3] && (digits_q[2] == 4'd0);
        blank[1] = blank[2] && (digits_q[1] == 4'd0);
        blank[0] = 1'b0;
    end

    always_comb begin
        seg_d = seg_decode(digits_q[idx_q]);
        an_d  = ~(4'b0001 << idx_q);
        if (state == STATE_POWER_ON) begin
            seg_d = SEG_DASH;
        end else begin
            if (blank[idx_q]) begin
                seg_d = SEG_OFF;
                an_d  = 4'hF;
            end
            if (state == STATE_GAME_OVER && blink_phase_q) begin
                seg_d = SEG_OFF;
                an_d  = 4'hF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_OFF;
            an  <= 4'hF;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_score_seg_display.sv
// Directed self-checking bench for score_seg_display with short scan and blink periods.
module tb_score_seg_display;

    localparam int unsigned SCAN_DIV  = 4;
    localparam int unsigned BLINK_DIV = 64;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] score;
    logic [2:0] state;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       bcd_valid;

    int n_tests = 0;
    int n_fail  = 0;

    score_seg_display #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .score     (score),
        .state     (state),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .bcd_valid (bcd_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts ticks from a score change (or reset release) until bcd_valid rises.
    task automatic expect_latency(input string tag, input int exp_ticks);
        int n;
        tick();
        n = 1;
        check_eq({tag, "_drop"}, 32'(bcd_valid), 32'd0);
        while (!bcd_valid && n < 40) begin
            tick();
            n++;
        end
        check_eq({tag, "_latency"}, n, exp_ticks);
    endtask

    // One full 16-cycle scan period: every lit digit shows its segments for 4 cycles.
    task automatic scan_window(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                               input logic [6:0] s1, input logic [6:0] s0,
                               input logic [3:0] blank);
        logic [6:0] exp_seg [4];
        int lit [4];
        int dark;
        int nblank;
        exp_seg[0] = s0;
        exp_seg[1] = s1;
        exp_seg[2] = s2;
        exp_seg[3] = s3;
        lit    = '{0, 0, 0, 0};
        dark   = 0;
        nblank = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (an == 4'hF) begin
                dark++;
                check_eq({tag, "_dark_seg"}, 32'(seg), 32'(SEG_OFF));
            end else begin
                int k;
                int zeros;
                k = 0;
                zeros = 0;
                for (int j = 0; j < 4; j++) begin
                    if (!an[j]) begin
                        zeros++;
                        k = j;
                    end
                end
                check_eq({tag, "_an_onehot"}, zeros, 1);
                check_eq({tag, "_seg"}, 32'(seg), 32'(exp_seg[k]));
                lit[k]++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            check_eq({tag, "_lit_count"}, lit[j], blank[j] ? 0 : 4);
            nblank += int'(blank[j]);
        end
        check_eq({tag, "_dark_count"}, dark, 4 * nblank);
        check_eq({tag, "_dp"}, 32'(dp), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_seg"}, 32'(seg), 32'(SEG_OFF));
        check_eq({tag, "_an"}, 32'(an), 32'hF);
        check_eq({tag, "_dp"}, 32'(dp), 32'd1);
        check_eq({tag, "_valid"}, 32'(bcd_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic v [1:30];
        int cnt;

        // 1. reset with score 0
        rst   = 1'b1;
        score = 10'd0;
        state = 3'd2;
        repeat (3) tick();
        check_reset_outputs("t1_reset");
        rst = 1'b0;
        expect_latency("t1", 12);
        tick();
        scan_window("t1", SEG_OFF, SEG_OFF, SEG_OFF, SEG_0, 4'b1110);

        // 2. full-scale score
        score = 10'd1023;
        expect_latency("t2", 12);
        tick();
        scan_window("t2", SEG_1, SEG_0, SEG_2, SEG_3, 4'b0000);

        // 3. 9 -> 10 crosses a digit boundary
        score = 10'd9;
        expect_latency("t3a", 12);
        tick();
        tick();
        score = 10'd10;
        expect_latency("t3b", 12);
        tick();
        scan_window("t3", SEG_OFF, SEG_OFF, SEG_1, SEG_0, 4'b1100);

        // 4. score changes during SHIFT are picked up by the next IDLE check
        score = 10'd5;
        for (int i = 1; i <= 30; i++) begin
            tick();
            v[i] = bcd_valid;
            if (i == 2) score = 10'd7;
        end
        check_eq("t4_valid_t11", 32'(v[11]), 32'd0);
        check_eq("t4_valid_t12", 32'(v[12]), 32'd1);
        check_eq("t4_valid_t13", 32'(v[13]), 32'd0);
        check_eq("t4_valid_t23", 32'(v[23]), 32'd0);
        check_eq("t4_valid_t24", 32'(v[24]), 32'd1);
        check_eq("t4_valid_t30", 32'(v[30]), 32'd1);
        scan_window("t4", SEG_OFF, SEG_OFF, SEG_OFF, SEG_7, 4'b1110);

        // 5. GameOver blink, then leave mid-off-phase
        score = 10'd42;
        expect_latency("t5", 12);
        tick();
        state = 3'd7;
        cnt = 0;
        repeat (64) begin tick(); if (an != 4'hF) cnt++; end
        check_eq("t5_lit_phase0", cnt, 32);
        cnt = 0;
        repeat (64) begin tick(); if (an != 4'hF) cnt++; end
        check_eq("t5_off_phase", cnt, 0);
        cnt = 0;
        repeat (64) begin tick(); if (an != 4'hF) cnt++; end
        check_eq("t5_lit_phase1", cnt, 32);
        repeat (20) tick();
        check_eq("t5_mid_off_an", 32'(an), 32'hF);
        state = 3'd2;
        scan_window("t5", SEG_OFF, SEG_OFF, SEG_4, SEG_2, 4'b1100);

        // 6. PowerOn dashes, then reset in the middle of a conversion
        state = 3'd0;
        scan_window("t6_dash", SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, 4'b0000);
        score = 10'd300;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("t6_reset");
        rst = 1'b0;
        expect_latency("t6", 12);
        state = 3'd2;
        tick();
        scan_window("t6", SEG_OFF, SEG_3, SEG_0, SEG_0, 4'b1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
